axi2noc_rdata_packetizer: RTL and testbench

Converts AXI4 read-data (R channel) bursts into NoC read-response packets: one head flit, one data flit per R beat, one tail flit. It is the transmit-side counterpart of the noc2axi4_master receive path. Store-and-forward: a burst, or a segment of one, is collected into a local buffer before its head is sent, so the head carries an exact beat count. Single clock domain (noc_clk).

---
 rtl/axi2noc_rdata_packetizer.sv | 204 ++++++++++++++++++++
 tb/tb_axi2noc_rdata_packetizer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi2noc_rdata_packetizer.sv
// axi2noc_rdata_packetizer
//
// Turns AXI4 R-channel bursts into NoC read-response packets.
// Each packet is a head flit, one data flit per buffered beat, then a tail flit.
// Beats are collected into a local buffer before the head is sent, so the head
// carries the exact beat count of its packet.
// Bursts longer than MAX_BEATS are split into several packets. Every tail except
// the last one of a burst has its cont bit set.
//
// Ports:
//   noc_clk, noc_rst      clock, synchronous active-high reset
//   cfg_dst_id/src_id/vc  routing fields, captured on the first beat of a packet
//   s_axi_r*              AXI4 read-data slave channel (rready is an output)
//   axi2noc_data          {flit_valid, flit[DATA_WIDTH-1:0]}
//   m_is_head, m_is_tail  flags that mark the head and tail flits
//   noc_ready             NoC accepts the presented flit this cycle
//   pkt_busy              a packet is being collected or drained
module axi2noc_rdata_packetizer #(
    parameter int DATA_WIDTH   = 128,
    parameter int AXI_ID_WIDTH = 4,
    parameter int MAX_BEATS    = 16
) (
    input  logic                    noc_clk,
    input  logic                    noc_rst,
    input  logic [3:0]              cfg_dst_id,
    input  logic [3:0]              cfg_src_id,
    input  logic [2:0]              cfg_vc,
    input  logic [AXI_ID_WIDTH-1:0] s_axi_rid,
    input  logic [DATA_WIDTH-1:0]   s_axi_rdata,
    input  logic [1:0]              s_axi_rresp,
    input  logic                    s_axi_rlast,
    input  logic                    s_axi_rvalid,
    output logic                    s_axi_rready,
    output logic [DATA_WIDTH:0]     axi2noc_data,
    output logic                    m_is_head,
    output logic                    m_is_tail,
    input  logic                    noc_ready,
    output logic                    pkt_busy
);

    localparam int PTR_W = $clog2(MAX_BEATS);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_COLLECT, S_HEAD, S_DATA, S_TAIL} state_e;

    typedef struct packed {
        logic [3:0]              dst;
        logic [3:0]              src;
        logic [2:0]              vc;
        logic [AXI_ID_WIDTH-1:0] rid;
    } meta_t;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]             resp_q, resp_d;
    logic                   cont_q, cont_d;
    meta_t                  meta_q, meta_d;
    // Holds rready low through the reset cycle.
    // rready can only rise once reset has been released.
    logic                   en_q;
    logic [DATA_WIDTH-1:0]  mem_q [MAX_BEATS];

    logic                   accept;
    logic                   vld;
    logic [DATA_WIDTH-1:0]  flit;
    logic [3:0]             rid_ext;
    logic [15:0]            cnt_ext;

    assign s_axi_rready = en_q && (state_q == S_COLLECT) && (count_q < CNT_W'(MAX_BEATS));
    assign accept       = s_axi_rvalid && s_axi_rready;
    assign pkt_busy     = (state_q != S_COLLECT) || (count_q != '0);

    always_comb begin
        rid_ext = '0;
        rid_ext[AXI_ID_WIDTH-1:0] = meta_q.rid;
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = count_q;
    end

    // Next-state logic.
    // In the drain states vld is 1, so noc_ready alone marks a flit transfer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        resp_d   = resp_q;
        cont_d   = cont_q;
        meta_d   = meta_q;
        case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (s_axi_rresp > resp_q) resp_d = s_axi_rresp;
                    // The first beat of a packet fixes its routing fields and id.
                    // Later rid changes inside the packet are ignored.
                    if (count_q == '0) begin
                        meta_d.dst = cfg_dst_id;
                        meta_d.src = cfg_src_id;
                        meta_d.vc  = cfg_vc;
                        meta_d.rid = s_axi_rid;
                    end
                    if (s_axi_rlast) begin
                        state_d = S_HEAD;
                        cont_d  = 1'b0;
                    end else if (count_q == CNT_W'(MAX_BEATS - 1)) begin
                        state_d = S_HEAD;
                        cont_d  = 1'b1;
                    end
                end
            end
            S_HEAD: begin
                if (noc_ready) begin
                    rd_ptr_d = '0;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (noc_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if ({1'b0, rd_ptr_q} == count_q - CNT_W'(1)) state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (noc_ready) begin
                    count_d = '0;
                    resp_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    // Flit output logic.
    // All outputs decode from registered state, so they stay stable while noc_ready is 0.
    always_comb begin
        flit      = '0;
        vld       = 1'b0;
        m_is_head = 1'b0;
        m_is_tail = 1'b0;
        case (state_q)
            S_HEAD: begin
                vld            = 1'b1;
                m_is_head      = 1'b1;
                flit[127:124]  = 4'h5;
                flit[123:120]  = meta_q.dst;
                flit[119:116]  = meta_q.src;
                flit[115:113]  = meta_q.vc;
                flit[112:97]   = cnt_ext;
                flit[56:53]    = 4'hA;
                flit[52:49]    = rid_ext;
                flit[2:0]      = 3'b111;
            end
            S_DATA: begin
                vld  = 1'b1;
                flit = mem_q[rd_ptr_q];
            end
            S_TAIL: begin
                vld            = 1'b1;
                m_is_tail      = 1'b1;
                flit[123:120]  = meta_q.dst;
                flit[119:116]  = meta_q.src;
                flit[115:113]  = meta_q.vc;
                flit[112:97]   = cnt_ext;
                flit[56:53]    = 4'hF;
                flit[52:49]    = rid_ext;
                flit[48:47]    = resp_q;
                flit[46]       = cont_q;
                flit[2:0]      = 3'b111;
            end
            default: ;
        endcase
    end

    assign axi2noc_data = {vld, flit};

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q  <= S_COLLECT;
            count_q  <= '0;
            rd_ptr_q <= '0;
            resp_q   <= '0;
            cont_q   <= 1'b0;
            meta_q   <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            resp_q   <= resp_d;
            cont_q   <= cont_d;
            meta_q   <= meta_d;
            en_q     <= 1'b1;
        end
    end

    // The buffer needs no reset.
    // Only entries below count are ever read, and every one of them is written first.
    always_ff @(posedge noc_clk) begin
        if (accept) mem_q[count_q[PTR_W-1:0]] <= s_axi_rdata;
    end

endmodule

// File: tb/tb_axi2noc_rdata_packetizer.sv
module tb_axi2noc_rdata_packetizer;

    logic         noc_clk = 1'b0;
    logic         noc_rst = 1'b1;
    logic [3:0]   cfg_dst_id = '0;
    logic [3:0]   cfg_src_id = '0;
    logic [2:0]   cfg_vc = '0;
    logic [3:0]   s_axi_rid = '0;
    logic [127:0] s_axi_rdata = '0;
    logic [1:0]   s_axi_rresp = '0;
    logic         s_axi_rlast = 1'b0;
    logic         s_axi_rvalid = 1'b0;
    logic         s_axi_rready;
    logic [128:0] axi2noc_data;
    logic         m_is_head;
    logic         m_is_tail;
    logic         noc_ready = 1'b1;
    logic         pkt_busy;

    always #5 noc_clk = ~noc_clk;

    axi2noc_rdata_packetizer #(.DATA_WIDTH(128), .AXI_ID_WIDTH(4), .MAX_BEATS(16)) dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst),
        .cfg_dst_id(cfg_dst_id), .cfg_src_id(cfg_src_id), .cfg_vc(cfg_vc),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .axi2noc_data(axi2noc_data), .m_is_head(m_is_head), .m_is_tail(m_is_tail),
        .noc_ready(noc_ready), .pkt_busy(pkt_busy)
    );

    int checks = 0;
    int failures = 0;
    logic [129:0] mq[$];      // transferred flits: {head, tail, flit}
    int vld_cyc = 0;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    always @(negedge noc_clk) begin
        if (!noc_rst) begin
            chk("head_tail_excl", 132'(m_is_head & m_is_tail), 132'(0));
            chk("collect_drain_excl", 132'(s_axi_rready & axi2noc_data[128]), 132'(0));
            if (axi2noc_data[128]) vld_cyc++;
            if (axi2noc_data[128] && noc_ready)
                mq.push_back({m_is_head, m_is_tail, axi2noc_data[127:0]});
        end
    end

    function automatic logic [127:0] exp_head(input logic [3:0] d, input logic [3:0] s,
                                             input logic [2:0] v, input logic [15:0] c,
                                             input logic [3:0] r);
        logic [127:0] h;
        h = '0;
        h[127:124] = 4'h5; h[123:120] = d; h[119:116] = s; h[115:113] = v;
        h[112:97] = c; h[56:53] = 4'hA; h[52:49] = r; h[2:0] = 3'b111;
        return h;
    endfunction

    function automatic logic [127:0] exp_tail(input logic [3:0] d, input logic [3:0] s,
                                             input logic [2:0] v, input logic [15:0] c,
                                             input logic [3:0] r, input logic [1:0] rs,
                                             input logic ct);
        logic [127:0] t;
        t = '0;
        t[123:120] = d; t[119:116] = s; t[115:113] = v; t[112:97] = c;
        t[56:53] = 4'hF; t[52:49] = r; t[48:47] = rs; t[46] = ct; t[2:0] = 3'b111;
        return t;
    endfunction

    // Sends one burst, waiting (bounded) for rready on every beat.
    // Returns one time step after the edge that accepted the closing beat.
    task automatic send_burst(input int len, input logic [3:0] rid, input logic [127:0] base,
                              input logic [31:0] resps);
        for (int i = 0; i < len; i++) begin
            int   t;
            logic ok;
            s_axi_rvalid = 1'b1;
            s_axi_rid    = rid;
            s_axi_rdata  = base + 128'(i);
            s_axi_rresp  = (i < 16) ? resps[2*i +: 2] : 2'b00;
            s_axi_rlast  = (i == len - 1);
            ok = 1'b0;
            t  = 0;
            while (!ok && t < 200) begin
                @(negedge noc_clk);
                ok = s_axi_rready;
                @(posedge noc_clk);
                #1;
                t++;
            end
            chk($sformatf("beat_accept[%0d]", i), 132'(ok), 132'(1));
        end
        s_axi_rvalid = 1'b0;
        s_axi_rlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (pkt_busy && t < 500) begin
            @(posedge noc_clk);
            #1;
            t++;
        end
        chk("idle_timeout", 132'(pkt_busy), 132'(0));
    endtask

    task automatic chk_pkt(input string tag, input logic [3:0] d, input logic [3:0] s,
                           input logic [2:0] v, input logic [3:0] r, input int cnt,
                           input logic [127:0] base, input logic [1:0] rs, input logic ct);
        if (mq.size() < cnt + 2) begin
            chk({tag, "_pkt_len"}, 132'(mq.size()), 132'(cnt + 2));
        end else begin
            chk({tag, "_head"}, 132'(mq.pop_front()), {4'b0010, exp_head(d, s, v, 16'(cnt), r)});
            for (int i = 0; i < cnt; i++)
                chk($sformatf("%s_data[%0d]", tag, i), 132'(mq.pop_front()), {4'b0000, base + 128'(i)});
            chk({tag, "_tail"}, 132'(mq.pop_front()), {4'b0001, exp_tail(d, s, v, 16'(cnt), r, rs, ct)});
        end
    endtask

    typedef struct {
        int           len;
        logic [3:0]   rid;
        logic [127:0] base;
        logic [31:0]  resps;      // 2 bits per beat, beat 0 in [1:0]
        logic [3:0]   dst;
        logic [3:0]   src;
        logic [2:0]   vc;
        logic [1:0]   exp_resp;
        int           exp_low;    // cycles with rready low after the closing beat
        int           exp_vld;    // cycles with flit valid
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{4, 4'h3, 128'h1,  32'h0,  4'h5, 4'h1, 3'h1, 2'b00, 6, 6};
        tbl[1] = '{4, 4'h2, 128'h10, 32'h38, 4'h2, 4'h7, 3'h3, 2'b11, 6, 6};
        tbl[2] = '{4, 4'h1, 128'h20, 32'h0,  4'h2, 4'h7, 3'h3, 2'b00, 6, 6};
        tbl[3] = '{1, 4'h9, 128'hAA, 32'h0,  4'h3, 4'h2, 3'h5, 2'b00, 3, 3};

        // Reset state
        repeat (3) begin @(posedge noc_clk); #1; end
        chk("rst_data", 132'(axi2noc_data), 132'(0));
        chk("rst_head", 132'(m_is_head), 132'(0));
        chk("rst_tail", 132'(m_is_tail), 132'(0));
        chk("rst_rready", 132'(s_axi_rready), 132'(0));
        chk("rst_busy", 132'(pkt_busy), 132'(0));
        noc_rst = 1'b0;
        @(posedge noc_clk); #1;
        chk("post_rst_rready", 132'(s_axi_rready), 132'(1));

        // Table-driven bursts with noc_ready held at 1
        for (int i = 0; i < 4; i++) begin
            int v0;
            int low;
            cfg_dst_id = tbl[i].dst; cfg_src_id = tbl[i].src; cfg_vc = tbl[i].vc;
            v0 = vld_cyc;
            send_burst(tbl[i].len, tbl[i].rid, tbl[i].base, tbl[i].resps);
            chk($sformatf("v%0d_head_latency", i), 132'({axi2noc_data[128], m_is_head, m_is_tail}), 132'(3'b110));
            low = 0;
            while (!s_axi_rready && low < 100) begin
                low++;
                @(posedge noc_clk); #1;
            end
            chk($sformatf("v%0d_rready_low", i), 132'(low), 132'(tbl[i].exp_low));
            wait_idle();
            chk($sformatf("v%0d_vld_cycles", i), 132'(vld_cyc - v0), 132'(tbl[i].exp_vld));
            if (i == 0 && mq.size() == 6) begin
                chk("v0_head_literal", 132'(mq[0]), {4'b0010, 128'h55120008_00000000_01460000_00000007});
                chk("v0_tail_literal", 132'(mq[5]), {4'b0001, 128'h05120008_00000000_01E60000_00000007});
            end
            chk_pkt($sformatf("v%0d", i), tbl[i].dst, tbl[i].src, tbl[i].vc, tbl[i].rid,
                    tbl[i].len, tbl[i].base, tbl[i].exp_resp, 1'b0);
            chk($sformatf("v%0d_q_empty", i), 132'(mq.size()), 132'(0));
        end

        // Backpressure: stall for 3 cycles while data flit 2 is presented
        begin
            int t;
            cfg_dst_id = 4'h5; cfg_src_id = 4'h1; cfg_vc = 3'h1;
            send_burst(4, 4'h3, 128'h1, 32'h0);
            t = 0;
            while (!(axi2noc_data == {1'b1, 128'h2} && !m_is_head && !m_is_tail) && t < 50) begin
                @(posedge noc_clk); #1;
                t++;
            end
            chk("stall_find_flit2", 132'(t < 50), 132'(1));
            noc_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(posedge noc_clk); #1;
                chk($sformatf("stall_hold[%0d]", k), 132'({m_is_head, m_is_tail, axi2noc_data}),
                    {1'b0, 2'b00, 1'b1, 128'h2});
            end
            noc_ready = 1'b1;
            wait_idle();
            chk_pkt("stall", 4'h5, 4'h1, 3'h1, 4'h3, 4, 128'h1, 2'b00, 1'b0);
            chk("stall_q_empty", 132'(mq.size()), 132'(0));
        end

        // 20-beat burst splits into 16 + 4
        cfg_dst_id = 4'hB; cfg_src_id = 4'h4; cfg_vc = 3'h2;
        send_burst(20, 4'h6, 128'h1, 32'h0);
        wait_idle();
        chk_pkt("splitA", 4'hB, 4'h4, 3'h2, 4'h6, 16, 128'h1, 2'b00, 1'b1);
        chk_pkt("splitB", 4'hB, 4'h4, 3'h2, 4'h6, 4, 128'h11, 2'b00, 1'b0);
        chk("split_q_empty", 132'(mq.size()), 132'(0));

        // Reset in the middle of DATA after 2 data flits
        cfg_dst_id = 4'h7; cfg_src_id = 4'h3; cfg_vc = 3'h4;
        send_burst(4, 4'h5, 128'h40, 32'h0);
        repeat (3) begin @(posedge noc_clk); #1; end
        chk("mid_pre_rst", 132'({m_is_head, m_is_tail, axi2noc_data}), {1'b0, 2'b00, 1'b1, 128'h42});
        noc_rst = 1'b1;
        @(posedge noc_clk); #1;
        chk("mid_rst_data", 132'(axi2noc_data), 132'(0));
        chk("mid_rst_flags", 132'({m_is_head, m_is_tail}), 132'(0));
        chk("mid_rst_rready", 132'(s_axi_rready), 132'(0));
        chk("mid_rst_busy", 132'(pkt_busy), 132'(0));
        noc_rst = 1'b0;
        @(posedge noc_clk); #1;
        chk("mid_post_rready", 132'(s_axi_rready), 132'(1));
        mq.delete();
        cfg_dst_id = 4'h9; cfg_src_id = 4'h4; cfg_vc = 3'h6;
        send_burst(2, 4'hC, 128'h70, 32'h0);
        wait_idle();
        chk_pkt("after_rst", 4'h9, 4'h4, 3'h6, 4'hC, 2, 128'h70, 2'b00, 1'b0);
        chk("after_rst_q_empty", 132'(mq.size()), 132'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
